input_event_scheduler: RTL and testbench

INPUT_EVENT_SCHEDULER -- requirements
Module: input_event_scheduler

---
 rtl/input_event_scheduler.sv | 106 ++++++++++
 tb/tb_input_event_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_event_scheduler.sv
// input_event_scheduler: edge-captures level requests and issues them as round-robin one-hot pulses with idle gaps
// Ports:
//   clk        system clock, all state on posedge
//   reset_n    asynchronous active-low reset
//   req        level requests, one event per rising edge
//   ready      downstream accept, sampled only while idle
//   out_pulse  registered one-hot single-cycle event pulse
//   out_id     index of last issued requester, held between pulses
//   pending    captured events not yet issued
//   overflow   sticky per-requester lost-event flag
//   busy       scheduler is issuing or waiting out a gap
module input_event_scheduler #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     ready,
    output logic [N_REQ-1:0]         out_pulse,
    output logic [$clog2(N_REQ)-1:0] out_id,
    output logic [N_REQ-1:0]         pending,
    output logic [N_REQ-1:0]         overflow,
    output logic                     busy
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t         state, state_n;
    logic [N_REQ-1:0] req_prev, rise, gnt, pulse_n, pending_n, overflow_n;
    logic [IW-1:0]  ptr, ptr_n, win, id_n;
    logic [IW:0]    idx;
    logic           found;
    logic [7:0]     cnt, cnt_n;

    assign rise = req & ~req_prev;
    assign busy = state != IDLE;

    // round-robin search starting at ptr, wrapping modulo N_REQ
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            idx = idx >= (IW+1)'(N_REQ) ? idx - (IW+1)'(N_REQ) : idx;
            if (!found && pending[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        gnt     = '0;
        pulse_n = '0;
        id_n    = out_id;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: if (found && ready) begin
                state_n  = ISSUE;
                gnt[win] = 1'b1;
                pulse_n  = gnt;
                id_n     = win;
                ptr_n    = win == IW'(N_REQ-1) ? '0 : win + 1'b1;
            end
            ISSUE: begin
                state_n = GAP_CYCLES > 0 ? GAP : IDLE;
                cnt_n   = 8'(GAP_CYCLES);
            end
            GAP: begin
                state_n = cnt <= 8'd1 ? IDLE : GAP;
                cnt_n   = cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
        // a rise coinciding with its own grant re-arms pending instead of overflowing
        pending_n  = (pending & ~gnt) | rise;
        overflow_n = overflow | (rise & pending & ~gnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_prev  <= '0;
            out_pulse <= '0;
            out_id    <= '0;
            pending   <= '0;
            overflow  <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            req_prev  <= req;
            out_pulse <= pulse_n;
            out_id    <= id_n;
            pending   <= pending_n;
            overflow  <= overflow_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_input_event_scheduler.sv
// tb_input_event_scheduler: scoreboard bench for input_event_scheduler with N_REQ=4, GAP_CYCLES=2
module tb_input_event_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0;
    logic       ready = 1'b0;
    logic [3:0] out_pulse;
    logic [1:0] out_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q[$];
    int pulse_cyc[$];

    input_event_scheduler #(.N_REQ(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ready(ready),
        .out_pulse(out_pulse), .out_id(out_id), .pending(pending),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (out_pulse !== 4'b0) begin
                checks++;
                pulse_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got pulse %b id %0d, expected no pulse", out_pulse, out_id);
                end else begin
                    int e;
                    logic [3:0] ep;
                    e = q.pop_front();
                    ep = 4'(1 << e);
                    if (out_pulse !== ep || out_id !== 2'(e)) begin
                        errors++;
                        $display("FAIL pulse_order: got pulse %b id %0d, expected pulse %b id %0d", out_pulse, out_id, ep, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        ready = 1'b0;
        tick(3);
        q.delete();
        pulse_cyc.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pulses outstanding, expected 0", name, q.size());
        end
        tick(12);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_pulse, out_id, pending, overflow, busy} !== 15'b0) begin
            errors++;
            $display("FAIL reset_state: got pulse %b id %0d pend %b ovf %b busy %b, expected all zero", out_pulse, out_id, pending, overflow, busy);
        end
        do_reset();
    endtask

    task automatic test_hold();
        do_reset();
        ready = 1'b1;
        req = 4'b0100;
        q.push_back(2);
        tick(2);
        checks++;
        if (out_pulse !== 4'b0100) begin
            errors++;
            $display("FAIL latency: got pulse %b, expected 0100", out_pulse);
        end
        tick(48);
        req = '0;
        wait_drain("hold");
        checks++;
        if (out_id !== 2'd2 || overflow !== 4'b0) begin
            errors++;
            $display("FAIL hold_final: got id %0d ovf %b, expected id 2 ovf 0000", out_id, overflow);
        end
    endtask

    task automatic test_two();
        do_reset();
        ready = 1'b1;
        req = 4'b1001;
        q.push_back(0);
        q.push_back(3);
        tick(1);
        req = '0;
        wait_drain("two");
        checks++;
        if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 4) begin
            errors++;
            $display("FAIL two_spacing: got %0d pulses spacing %0d, expected 2 pulses spacing 4", pulse_cyc.size(), pulse_cyc.size() == 2 ? pulse_cyc[1] - pulse_cyc[0] : -1);
        end
    endtask

    task automatic test_ready();
        do_reset();
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(20);
        checks++;
        if (pending !== 4'b0010 || busy !== 1'b0 || out_pulse !== 4'b0) begin
            errors++;
            $display("FAIL ready_hold: got pend %b busy %b pulse %b, expected 0010 0 0000", pending, busy, out_pulse);
        end
        q.push_back(1);
        ready = 1'b1;
        tick(1);
        checks++;
        if (out_pulse !== 4'b0010 || pending !== 4'b0) begin
            errors++;
            $display("FAIL ready_issue: got pulse %b pend %b, expected 0010 0000", out_pulse, pending);
        end
        wait_drain("ready");
    endtask

    task automatic test_overflow();
        do_reset();
        req = 4'b0010; tick(1);
        req = '0;      tick(1);
        req = 4'b0010; tick(1);
        req = '0;      tick(1);
        checks++;
        if (overflow !== 4'b0010 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set: got ovf %b pend %b, expected 0010 0010", overflow, pending);
        end
        q.push_back(1);
        ready = 1'b1;
        wait_drain("ovf");
        checks++;
        if (overflow !== 4'b0010 || pending !== 4'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf %b pend %b, expected 0010 0000", overflow, pending);
        end
        do_reset();
        checks++;
        if (overflow !== 4'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf %b, expected 0000", overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) q.push_back(i);
        tick(1);
        req = '0;
        wait_drain("all");
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pulse_cyc.size() != 4 || pulse_cyc[i] - pulse_cyc[i-1] != 4) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d pulses spacing %0d, expected 4 pulses spacing 4", i, pulse_cyc.size(), pulse_cyc.size() == 4 ? pulse_cyc[i] - pulse_cyc[i-1] : -1);
            end
        end
        req = 4'b0101;
        q.push_back(0);
        q.push_back(2);
        tick(1);
        req = '0;
        wait_drain("wrap");
    endtask

    task automatic test_reset_gap();
        do_reset();
        ready = 1'b1;
        req = 4'b1001;
        q.push_back(0);
        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
        req = '0;
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b1 || q.size() != 0) begin
            errors++;
            $display("FAIL gap_setup: got pend %b busy %b queued %0d, expected 1000 1 0", pending, busy, q.size());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_pulse, out_id, pending, overflow, busy} !== 15'b0) begin
            errors++;
            $display("FAIL reset_async: got pulse %b id %0d pend %b ovf %b busy %b, expected all zero", out_pulse, out_id, pending, overflow, busy);
        end
        tick(2);
        reset_n = 1'b1;
        tick(20);
        checks++;
        if (pulse_cyc.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got %0d pulses busy %b, expected 1 pulse busy 0", pulse_cyc.size(), busy);
        end
    endtask

    task automatic test_req_at_release();
        reset_n = 1'b0;
        ready = 1'b1;
        req = 4'b0010;
        tick(2);
        q.delete();
        pulse_cyc.delete();
        q.push_back(1);
        reset_n = 1'b1;
        wait_drain("release");
        checks++;
        if (pulse_cyc.size() != 1) begin
            errors++;
            $display("FAIL release_once: got %0d pulses, expected 1", pulse_cyc.size());
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_two();
        test_ready();
        test_overflow();
        test_back_to_back();
        test_reset_gap();
        test_req_at_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
